// File: rtl/flash_cfg_reader.sv
// SPI-flash configuration reader: after reset, waits out the chip-select gap, issues READ (0x03) at ADDR,
// shifts in BYTES bytes over a mode-0 SPI link and holds them on q until restarted.
//
// state  | meaning
// S_WAIT | cs high, counting the minimum deselect gap
// S_CMD  | shifting out opcode + 24-bit address, miso ignored
// S_DATA | shifting in data bits, mosi held low
// S_DONE | pins idle, q valid, waiting for restart
module flash_cfg_reader #(
    parameter logic [23:0] ADDR  = 24'h00704D,
    parameter int          BYTES = 2,
    parameter int          CSGAP = 14
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce,
    input  logic               restart,
    output logic               busy,
    output logic               valid,
    output logic [8*BYTES-1:0] q,
    output logic               cs,
    output logic               ck,
    output logic               mosi,
    input  logic               miso
);

    localparam int              N       = 8 * BYTES;
    localparam int              GW      = $clog2(CSGAP) + 1;
    localparam logic [31:0]     FRAME   = {8'h03, ADDR};
    localparam logic [6:0]      LAST    = 7'(32 + N - 1);
    localparam logic [GW-1:0]   GAP_END = GW'(CSGAP - 1);

    typedef enum logic [1:0] {S_WAIT, S_CMD, S_DATA, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   gap;
    logic [6:0]      idx;
    logic [N-1:0]    rx;
    logic [4:0]      fsel;
    logic            gap_hit;

    assign gap_hit = (gap == GAP_END);
    assign fsel    = 5'd30 - idx[4:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_WAIT;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // phase B of a bit cell is the tick where ck is currently high
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: if (gap_hit) state_nxt = S_CMD;
            S_CMD:  if (ck && idx == 7'd31) state_nxt = S_DATA;
            S_DATA: if (ck && idx == LAST) state_nxt = S_DONE;
            S_DONE: if (restart) state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        cs    = 1'b1;
        busy  = 1'b0;
        valid = 1'b0;
        case (state)
            S_CMD, S_DATA: begin
                cs   = 1'b0;
                busy = 1'b1;
            end
            S_DONE: valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gap  <= '0;
            idx  <= '0;
            rx   <= '0;
            q    <= '0;
            ck   <= 1'b0;
            mosi <= 1'b0;
        end else if (ce) begin
            case (state)
                S_WAIT: begin
                    gap <= gap + GW'(1);
                    if (gap_hit) begin
                        mosi <= FRAME[31];
                        idx  <= '0;
                        ck   <= 1'b0;
                    end
                end
                S_CMD, S_DATA: begin
                    if (!ck) begin
                        ck <= 1'b1;
                        if (state == S_DATA) rx <= {rx[N-2:0], miso};
                    end else begin
                        ck  <= 1'b0;
                        idx <= idx + 7'd1;
                        if (state == S_CMD) begin
                            mosi <= (idx == 7'd31) ? 1'b0 : FRAME[fsel];
                        end else if (idx == LAST) begin
                            q <= rx;
                        end
                    end
                end
                S_DONE: begin
                    if (restart) gap <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_cfg_reader.sv
// Bench for flash_cfg_reader: two instances (default and 1-byte/short-gap), a behavioural SPI flash
// per instance, a q scoreboard and a continuous pin-protocol monitor.
module tb_flash_cfg_reader;

    logic        clock;
    logic        ce;
    logic        ce_en;
    logic        rst     [2];
    logic        restart [2];
    logic        busy_a  [2];
    logic        valid_a [2];
    logic        cs_a    [2];
    logic        ck_a    [2];
    logic        mosi_a  [2];
    logic        miso_a  [2];
    logic [15:0] q0;
    logic [7:0]  q1;

    int          checks = 0;
    int          failures = 0;
    int          tick      [2] = '{0, 0};
    int          edges     [2] = '{0, 0};
    int          cs_fall_t [2] = '{0, 0};
    int          cs_low_n  [2] = '{0, 0};
    int          valid_t   [2] = '{0, 0};
    logic [31:0] cmd       [2] = '{0, 0};
    logic [31:0] resp      [2] = '{0, 0};
    logic [31:0] expq0 [$];
    logic [31:0] expq1 [$];

    flash_cfg_reader dut0 (
        .clock(clock), .reset(rst[0]), .ce(ce), .restart(restart[0]),
        .busy(busy_a[0]), .valid(valid_a[0]), .q(q0),
        .cs(cs_a[0]), .ck(ck_a[0]), .mosi(mosi_a[0]), .miso(miso_a[0])
    );

    flash_cfg_reader #(.ADDR(24'h0B0000), .BYTES(1), .CSGAP(3)) dut1 (
        .clock(clock), .reset(rst[1]), .ce(ce), .restart(restart[1]),
        .busy(busy_a[1]), .valid(valid_a[1]), .q(q1),
        .cs(cs_a[1]), .ck(ck_a[1]), .mosi(mosi_a[1]), .miso(miso_a[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // one-clock ce every 8 clocks, changed on the falling edge
    initial begin
        int div;
        div = 0;
        ce  = 1'b0;
        forever begin
            @(negedge clock);
            ce  = ce_en && (div == 7);
            div = (div + 1) % 8;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            for (int i = 0; i < 2; i++) begin
                if (!rst[i]) tick[i] = 0;
                else if (ce) tick[i]++;
            end
        end
    end

    // flash model + protocol monitor
    initial begin
        logic p_cs [2], p_ck [2], p_mosi [2], p_valid [2];
        int nb, j;
        p_cs = '{1, 1}; p_ck = '{0, 0}; p_mosi = '{0, 0}; p_valid = '{0, 0};
        miso_a = '{0, 0};
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                nb = (i == 0) ? 16 : 8;
                if (p_cs[i] && !cs_a[i]) begin
                    cs_fall_t[i] = tick[i];
                    edges[i]     = 0;
                    cmd[i]       = '0;
                    miso_a[i]    = 1'b0;
                end
                if (!p_cs[i] && cs_a[i]) cs_low_n[i] = tick[i] - cs_fall_t[i];
                if (!p_ck[i] && ck_a[i]) begin
                    if (edges[i] < 32) cmd[i] = {cmd[i][30:0], mosi_a[i]};
                    edges[i]++;
                end
                if (p_ck[i] && !ck_a[i] && edges[i] >= 32 && edges[i] < 32 + nb) begin
                    j = edges[i] - 32;
                    miso_a[i] = resp[i][nb-1-j];
                end
                if (!p_valid[i] && valid_a[i]) valid_t[i] = tick[i];
                if (cs_a[i]) chk("ck_low_while_cs_high", {31'b0, ck_a[i]}, 32'd0);
                if (p_ck[i] && ck_a[i]) chk("mosi_stable_ck_high", {31'b0, mosi_a[i]}, {31'b0, p_mosi[i]});
                if (valid_a[i]) chk("cs_high_in_done", {31'b0, cs_a[i]}, 32'd1);
                chk("busy_eq_not_cs", {31'b0, busy_a[i]}, {31'b0, ~cs_a[i]});
                p_cs[i] = cs_a[i]; p_ck[i] = ck_a[i]; p_mosi[i] = mosi_a[i]; p_valid[i] = valid_a[i];
            end
        end
    end

    task automatic wait_valid(input int i);
        int n;
        logic [31:0] e, obs;
        n = 0;
        while (!valid_a[i] && n < 4000) begin
            @(negedge clock);
            n++;
        end
        #1;
        chk("valid_timeout", {31'b0, valid_a[i]}, 32'd1);
        obs = (i == 0) ? {16'h0, q0} : {24'h0, q1};
        if (i == 0) e = (expq0.size() > 0) ? expq0.pop_front() : 32'hDEAD;
        else        e = (expq1.size() > 0) ? expq1.pop_front() : 32'hDEAD;
        chk("q_scoreboard", obs, e);
    endtask

    task automatic wait_edges(input int i, input int k);
        int n;
        n = 0;
        while (!(!cs_a[i] && edges[i] >= k) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        #1;
        chk("edge_wait_timeout", {31'b0, cs_a[i]}, 32'd0);
    endtask

    // restart high for exactly the clock carrying the next ce
    task automatic pulse_restart(input int i);
        do @(posedge clock); while (!ce);
        repeat (7) @(posedge clock);
        #1 restart[i] = 1'b1;
        @(posedge clock);
        #1 restart[i] = 1'b0;
    endtask

    initial begin
        int r, e_before;
        logic s_ck, s_cs, s_mosi, frozen;
        ce_en = 1'b1;
        rst = '{1, 1};
        restart = '{0, 0};
        #2 rst = '{0, 0};
        #1;
        chk("rst_cs", {31'b0, cs_a[0]}, 32'd1);
        chk("rst_ck", {31'b0, ck_a[0]}, 32'd0);
        chk("rst_mosi", {31'b0, mosi_a[0]}, 32'd0);
        chk("rst_busy", {31'b0, busy_a[0]}, 32'd0);
        chk("rst_valid", {31'b0, valid_a[0]}, 32'd0);
        chk("rst_q", {16'h0, q0}, 32'd0);
        chk("rst_cs_dut1", {31'b0, cs_a[1]}, 32'd1);

        // first read after reset
        repeat (3) @(negedge clock);
        resp[0] = 32'h025A;
        expq0.push_back(32'h025A);
        rst[0] = 1'b1;
        wait_valid(0);
        chk("a_cmd", cmd[0], 32'h0300704D);
        chk("a_valid_tick", valid_t[0], 32'd110);
        chk("a_cs_fall_tick", cs_fall_t[0], 32'd14);
        chk("a_cs_low", cs_low_n[0], 32'd96);
        chk("a_edges", edges[0], 32'd48);

        // restart from DONE, plus an ignored restart during CMD
        resp[0] = 32'hFF00;
        expq0.push_back(32'hFF00);
        pulse_restart(0);
        r = tick[0];
        chk("b_valid_drop", {31'b0, valid_a[0]}, 32'd0);
        wait_edges(0, 6);
        chk("b_cs_fall_tick", cs_fall_t[0], r + 14);
        pulse_restart(0);
        chk("b_restart_in_cmd", {31'b0, cs_a[0]}, 32'd0);
        wait_valid(0);
        chk("b_valid_tick", valid_t[0], r + 110);
        chk("b_cs_low", cs_low_n[0], 32'd96);
        chk("b_edges", edges[0], 32'd48);
        chk("b_cmd", cmd[0], 32'h0300704D);

        // ce frozen for 1000 clocks in the middle of the command
        resp[0] = 32'h025A;
        expq0.push_back(32'h025A);
        pulse_restart(0);
        r = tick[0];
        wait_edges(0, 10);
        @(posedge clock);
        #1 ce_en = 1'b0;
        @(negedge clock);
        #1;
        s_ck = ck_a[0]; s_cs = cs_a[0]; s_mosi = mosi_a[0];
        e_before = edges[0];
        frozen = 1'b1;
        repeat (1000) begin
            @(negedge clock);
            #1;
            if (ck_a[0] !== s_ck || cs_a[0] !== s_cs || mosi_a[0] !== s_mosi) frozen = 1'b0;
        end
        chk("c_pins_frozen", {31'b0, frozen}, 32'd1);
        chk("c_edges_frozen", edges[0], e_before);
        @(posedge clock);
        #1 ce_en = 1'b1;
        wait_valid(0);
        chk("c_edges", edges[0], 32'd48);
        chk("c_valid_tick", valid_t[0], r + 110);
        chk("c_cmd", cmd[0], 32'h0300704D);

        // async reset during data bit 5, then a clean re-run
        resp[0] = 32'h1111;
        pulse_restart(0);
        wait_edges(0, 38);
        @(negedge clock);
        #2 rst[0] = 1'b0;
        #1;
        chk("d_cs_async", {31'b0, cs_a[0]}, 32'd1);
        chk("d_ck_async", {31'b0, ck_a[0]}, 32'd0);
        chk("d_valid_async", {31'b0, valid_a[0]}, 32'd0);
        chk("d_q_async", {16'h0, q0}, 32'd0);
        chk("d_busy_async", {31'b0, busy_a[0]}, 32'd0);
        repeat (3) @(negedge clock);
        resp[0] = 32'hC33C;
        expq0.push_back(32'hC33C);
        rst[0] = 1'b1;
        wait_valid(0);
        chk("d_cs_fall_tick", cs_fall_t[0], 32'd14);
        chk("d_valid_tick", valid_t[0], 32'd110);
        chk("d_edges", edges[0], 32'd48);

        // 1-byte instance at 0x0B0000 with a 3-tick gap
        @(negedge clock);
        resp[1] = 32'hA7;
        expq1.push_back(32'hA7);
        rst[1] = 1'b1;
        wait_valid(1);
        chk("e_cmd", cmd[1], 32'h030B0000);
        chk("e_edges", edges[1], 32'd40);
        chk("e_cs_fall_tick", cs_fall_t[1], 32'd3);
        chk("e_valid_tick", valid_t[1], 32'd83);
        chk("e_cs_low", cs_low_n[1], 32'd80);

        repeat (4) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_cfg_reader.md
Name: flash_cfg_reader

Overview:
- Autonomous SPI-flash configuration reader for the top level.
- After reset it issues one standard READ (0x03) command at a fixed 24-bit address and shifts in BYTES bytes of board configuration, e.g. the BIOS video-mode byte that selects VGA or RGB at power-up.
- It drives the flash pins directly through an internal mode-0 shifter, then releases chip-select.
- It holds the result on q with valid high until restarted.

Parameters:
- ADDR, 24'h00704D, flash byte address placed after the 0x03 opcode, MSB first.
- BYTES, 2, number of data bytes read (1..4).
- CSGAP, 14, ce ticks chip-select is held high before the command starts (minimum deselect time).

Ports:
- clock  in  1  system clock (56 MHz).
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable, one clock wide (7 MHz); all state advances only when ce=1.
- restart  in  1  one-cycle pulse; re-runs the read from DONE.
- busy  out  1  high from leaving IDLE-wait until DONE.
- valid  out  1  high while q holds a completed read.
- q  out  8*BYTES  read data; first byte received in the MSBs.
- cs  out  1  flash chip-select, active-low.
- ck  out  1  SPI clock; idles low.
- mosi  out  1  SPI data to flash.
- miso  in  1  SPI data from flash.

Behaviour:
- Async reset (reset=0), effective immediately:
  - Outputs: cs=1, ck=0, mosi=0, busy=0, valid=0, q=0.
  - Internal state: state=WAIT, gap counter=0, bit counter=0.
  - Reset mid-transfer aborts the transfer; cs rises asynchronously.
- Register updates happen on the posedge clock with ce=1 only. ce=0 freezes everything, including ck.
- Frame:
  - 32-bit command word F = {8'h03, ADDR}, sent MSB first.
  - Followed by N = 8*BYTES data bits; mosi=0 during data bits.
- States:
  - WAIT: cs=1, busy=0. The gap counter increments each ce. On the ce where the counter equals CSGAP-1:
    - cs<=0, mosi<=F[31], busy<=1, bit index<=0, state<=CMD.
  - CMD and DATA bit cell, two ce ticks per bit:
    - Phase A (ck=0): ck<=1; rx<={rx[N-2:0], miso}. miso is sampled only in DATA; in CMD it is ignored.
    - Phase B (ck=1): ck<=0; bit index increments.
      - In CMD, mosi<=next bit of F.
      - On the falling edge ending bit 31: state<=DATA, mosi<=0.
      - On the falling edge ending the last data bit: state<=DONE, cs<=1, q<=rx (including the final bit), valid<=1, busy<=0.
  - DONE: pins idle (cs=1, ck=0, mosi=0); q and valid hold.
    - restart=1 on a ce tick: valid<=0, gap counter<=0, state<=WAIT (q retains its old value until overwritten).
    - restart is ignored in WAIT, CMD and DATA.
- Timing:
  - cs falls CSGAP ce ticks after reset release.
  - The transfer lasts 2*(32+N) ce ticks.
  - For the defaults: cs low for exactly 96 ce ticks; valid asserts 14+96 = 110 ce ticks after the first ce following reset release.
- SPI mode 0:
  - mosi changes only on ck falling edges, or on the cs-assert tick for bit 31.
  - miso is sampled on the rising-edge tick.
  - ck is never high while cs=1.
- Widths:
  - Bit index wide enough for 32+32 (7 bits).
  - Gap counter sized to clog2(CSGAP)+1; no wrap occurs in WAIT because the state exits on the match.
- Simultaneous events:
  - restart on the same tick that DONE is entered is ignored.
  - Async reset overrides everything.

Test Plan:
- Defaults, flash model returning 0x02,0x5A:
  - mosi bytes captured on ck rising edges = 03 00 70 4D.
  - q=16'h025A; valid rises at ce tick 110; cs low for exactly 96 ce ticks; 48 rising ck edges.
- ce held low for 1000 clocks mid-CMD: ck/cs/mosi frozen; resuming ce completes with the identical q and edge count.
- reset driven low at data bit 5: cs=1, ck=0, valid=0, q=0 within the same clock (async). After release, a full new frame with a fresh CSGAP wait gives a correct q.
- restart pulse in DONE with the model now returning 0xFF,0x00:
  - valid drops next ce; cs falls 14 ce later; new q=16'hFF00.
  - A restart pulse during CMD has no effect.
- BYTES=1, ADDR=24'h0B0000, CSGAP=3: command 03 0B 00 00; 40 ck edges; q equals the model byte; busy high exactly from cs fall to cs rise.
- Protocol checker for the whole run: no mosi change while ck=1; ck=0 whenever cs=1; cs is never low in DONE.
